cla_pipe_addsub: RTL and testbench

CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

---
 rtl/cla_pkg.sv | 9 +
 rtl/cla_4.sv | 27 ++
 rtl/cla_pipe_addsub.sv | 144 ++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_BLOCK = 8;
    localparam int unsigned GRP_BITS  = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/cla_4.sv
// 4-bit carry-lookahead group: sum bits plus group propagate/generate.
module cla_4
    import cla_pkg::*;
(
    input  logic [GRP_BITS-1:0] a,
    input  logic [GRP_BITS-1:0] b,
    input  logic                ci,
    output logic [GRP_BITS-1:0] s,
    output logic                P,
    output logic                G
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        s    = p ^ c;
        P    = &p;
        G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end
endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract: one BLOCK-bit slice resolved per stage, with
// skewed operand/sum registers and a stallable output register.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned BLOCK = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned NSTAGE = WIDTH / BLOCK;
    localparam int unsigned NGRP   = BLOCK / GRP_BITS;
    localparam int unsigned LAST   = NSTAGE - 1;

    logic             advance;
    logic [WIDTH-1:0] y_eff;
    logic             c0;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign y_eff    = (sub == OP_SUB) ? ~Y : Y;
    assign c0       = (sub == OP_ADD) ? Cin : 1'b1;

    for (genvar k = 0; k < NSTAGE; k++) begin : stg
        localparam int unsigned LO = k * BLOCK;

        logic                  v_in;
        logic                  c_in;
        logic [WIDTH-1:LO]     a_rem;
        logic [WIDTH-1:LO]     b_rem;
        logic [BLOCK-1:0]      a_s;
        logic [BLOCK-1:0]      b_s;
        logic [BLOCK-1:0]      s_blk;
        logic [LO+BLOCK-1:0]   sum_d;
        logic [NGRP:0]         gc;
        logic [NGRP-1:0]       gp;
        logic [NGRP-1:0]       gg;

        logic                  v_q;
        logic                  c_q;
        logic [LO+BLOCK-1:0]   sum_q;

        // Stage 0 takes the raw beat; later stages take the skewed registers.
        if (k == 0) begin : src
            assign v_in  = in_valid;
            assign c_in  = c0;
            assign a_rem = X;
            assign b_rem = y_eff;
            assign sum_d = s_blk;
        end else begin : src
            assign v_in  = stg[k-1].v_q;
            assign c_in  = stg[k-1].c_q;
            assign a_rem = stg[k-1].fwd.a_q;
            assign b_rem = stg[k-1].fwd.b_q;
            assign sum_d = {s_blk, stg[k-1].sum_q};
        end

        assign a_s   = a_rem[LO +: BLOCK];
        assign b_s   = b_rem[LO +: BLOCK];
        assign gc[0] = c_in;

        for (genvar g = 0; g < NGRP; g++) begin : grp
            cla_4 u_cla (
                .a  (a_s[g*GRP_BITS +: GRP_BITS]),
                .b  (b_s[g*GRP_BITS +: GRP_BITS]),
                .ci (gc[g]),
                .s  (s_blk[g*GRP_BITS +: GRP_BITS]),
                .P  (gp[g]),
                .G  (gg[g])
            );
            assign gc[g+1] = gg[g] | (gp[g] & gc[g]);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                v_q   <= v_in;
                c_q   <= gc[NGRP];
                sum_q <= sum_d;
            end
        end

        // Unresolved upper operand slices travel with the beat.
        if (k < LAST) begin : fwd
            logic [WIDTH-1:LO+BLOCK] a_q;
            logic [WIDTH-1:LO+BLOCK] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_rem[WIDTH-1:LO+BLOCK];
                    b_q <= b_rem[WIDTH-1:LO+BLOCK];
                end
            end
        end

        // Carry into the MSB, recovered from the MSB's sum and operand bits.
        if (k == LAST) begin : fin
            logic cm_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cm_q <= 1'b0;
                end else if (advance) begin
                    cm_q <= a_s[BLOCK-1] ^ b_s[BLOCK-1] ^ s_blk[BLOCK-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            out_valid <= stg[LAST].v_q;
            S         <= stg[LAST].sum_q;
            Cout      <= stg[LAST].c_q;
            ovf       <= stg[LAST].fin.cm_q ^ stg[LAST].c_q;
            zero      <= (stg[LAST].sum_q == '0);
        end
    end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed testbench for cla_pipe_addsub at WIDTH=16, BLOCK=4.
module tb_cla_pipe_addsub;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] X;
    logic [15:0] Y;
    logic        Cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Cout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;

    cla_pipe_addsub #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; X = 16'h1111; Y = 16'h2222;
        Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        tick; tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (S !== 16'h0000) begin errors++; $display("FAIL reset_S: got %h expected 0000", S); end
        checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL reset_Cout: got %b expected 0", Cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept c%0d: out_valid %b expected 0", c, out_valid); end
        end
    endtask

    task automatic test_add;
        logic [15:0] xv [4];
        logic [15:0] yv [4];
        logic        cv [4];
        logic [15:0] es [4];
        logic        ec [4];
        logic        eo [4];
        logic        ez [4];
        xv = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h1234};
        yv = '{16'hDDDD, 16'h0001, 16'h0001, 16'h4321};
        cv = '{1'b0, 1'b0, 1'b0, 1'b1};
        es = '{16'hDDDD, 16'h0000, 16'h8000, 16'h5556};
        ec = '{1'b0, 1'b1, 1'b0, 1'b0};
        eo = '{1'b0, 1'b0, 1'b1, 1'b0};
        ez = '{1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1; sub = 1'b0;
        for (int i = 0; i < 4; i++) begin
            X = xv[i]; Y = yv[i]; Cin = cv[i]; in_valid = 1'b1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add%0d_in_ready: got %b expected 1", i, in_ready); end
            tick;
            in_valid = 1'b0;
            for (int c = 1; c < 4; c++) begin
                tick;
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL add%0d_early c%0d: out_valid %b expected 0", i, c, out_valid); end
            end
            tick;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add%0d_out_valid: got %b expected 1", i, out_valid); end
            checks++; if (S !== es[i]) begin errors++; $display("FAIL add%0d_S: got %h expected %h", i, S, es[i]); end
            checks++; if (Cout !== ec[i]) begin errors++; $display("FAIL add%0d_Cout: got %b expected %b", i, Cout, ec[i]); end
            checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL add%0d_ovf: got %b expected %b", i, ovf, eo[i]); end
            checks++; if (zero !== ez[i]) begin errors++; $display("FAIL add%0d_zero: got %b expected %b", i, zero, ez[i]); end
        end
        tick;
    endtask

    task automatic test_sub;
        logic [15:0] xv [3];
        logic [15:0] yv [3];
        logic        cv [3];
        logic [15:0] es [3];
        logic        ec [3];
        logic        eo [3];
        logic        ez [3];
        xv = '{16'h0005, 16'h8000, 16'h1234};
        yv = '{16'h0007, 16'h0001, 16'h1234};
        cv = '{1'b1, 1'b0, 1'b1};
        es = '{16'hFFFE, 16'h7FFF, 16'h0000};
        ec = '{1'b0, 1'b1, 1'b1};
        eo = '{1'b0, 1'b1, 1'b0};
        ez = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b1; sub = 1'b1;
        for (int i = 0; i < 3; i++) begin
            X = xv[i]; Y = yv[i]; Cin = cv[i]; in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            for (int c = 1; c < 4; c++) begin
                tick;
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL sub%0d_early c%0d: out_valid %b expected 0", i, c, out_valid); end
            end
            tick;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub%0d_out_valid: got %b expected 1", i, out_valid); end
            checks++; if (S !== es[i]) begin errors++; $display("FAIL sub%0d_S: got %h expected %h", i, S, es[i]); end
            checks++; if (Cout !== ec[i]) begin errors++; $display("FAIL sub%0d_Cout: got %b expected %b", i, Cout, ec[i]); end
            checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL sub%0d_ovf: got %b expected %b", i, ovf, eo[i]); end
            checks++; if (zero !== ez[i]) begin errors++; $display("FAIL sub%0d_zero: got %b expected %b", i, zero, ez[i]); end
        end
        sub = 1'b0; Cin = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        int sent  = 0;
        int got   = 0;
        int first = -1;
        int last  = -1;
        out_ready = 1'b1; sub = 1'b0; Cin = 1'b0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (sent < 15);
            X = 16'(sent);
            Y = 16'hDDDD - 16'(sent);
            if (in_valid) sent++;
            tick;
            if (out_valid === 1'b1) begin
                checks++;
                if (S !== 16'hDDDD) begin errors++; $display("FAIL b2b_S c%0d: got %h expected dddd", c, S); end
                got++;
                if (first < 0) first = c;
                last = c;
            end
        end
        in_valid = 1'b0;
        checks++; if (got !== 15) begin errors++; $display("FAIL b2b_count: got %0d expected 15", got); end
        checks++; if (first !== 4) begin errors++; $display("FAIL b2b_first: got %0d expected 4", first); end
        checks++; if (last !== 18) begin errors++; $display("FAIL b2b_last: got %0d expected 18", last); end
    endtask

    task automatic test_order;
        int got = 0;
        logic [15:0] exp_s [8];
        out_ready = 1'b1; sub = 1'b0;
        for (int j = 0; j < 8; j++) exp_s[j] = 16'(j * 257 + 17 + (j % 2));
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 8);
            X = 16'(c * 257);
            Y = 16'h0011;
            Cin = 1'(c % 2);
            tick;
            if (out_valid === 1'b1) begin
                checks++;
                if (got >= 8) begin
                    errors++; $display("FAIL order_extra: result %0d beyond 8", got);
                end else if (S !== exp_s[got]) begin
                    errors++; $display("FAIL order_S%0d: got %h expected %h", got, S, exp_s[got]);
                end
                got++;
            end
        end
        in_valid = 1'b0; Cin = 1'b0;
        checks++; if (got !== 8) begin errors++; $display("FAIL order_count: got %0d expected 8", got); end
    endtask

    task automatic test_stall;
        int   sent = 0;
        int   got  = 0;
        logic mv [5];
        logic adv_m;
        for (int i = 0; i < 5; i++) mv[i] = 1'b0;
        sub = 1'b0; Cin = 1'b0;
        for (int c = 0; c < 200 && got < 15; c++) begin
            out_ready = ((c % 3) == 0);
            in_valid  = (sent < 15);
            X = 16'(sent);
            Y = 16'hDDDD - 16'(sent);
            #1;
            adv_m = !mv[4] || out_ready;
            checks++; if (in_ready !== adv_m) begin errors++; $display("FAIL stall_in_ready c%0d: got %b expected %b", c, in_ready, adv_m); end
            checks++; if (out_valid !== mv[4]) begin errors++; $display("FAIL stall_out_valid c%0d: got %b expected %b", c, out_valid, mv[4]); end
            if (mv[4]) begin
                checks++;
                if (S !== 16'hDDDD) begin errors++; $display("FAIL stall_S c%0d: got %h expected dddd", c, S); end
            end
            if (out_valid && out_ready) got++;
            if (in_valid && adv_m) sent++;
            if (adv_m) begin
                mv[4] = mv[3]; mv[3] = mv[2]; mv[2] = mv[1]; mv[1] = mv[0]; mv[0] = in_valid;
            end
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got !== 15) begin errors++; $display("FAIL stall_count: got %0d expected 15", got); end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_dup c%0d: out_valid %b expected 0", c, out_valid); end
            tick;
        end
    endtask

    task automatic test_mid_reset;
        logic [15:0] xv [3];
        logic [15:0] yv [3];
        xv = '{16'hFFFF, 16'h7FFF, 16'h1234};
        yv = '{16'h0001, 16'h0001, 16'h1111};
        out_ready = 1'b1; sub = 1'b0; Cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            X = xv[i]; Y = yv[i]; in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        tick; tick;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid: got %b expected 1", out_valid); end
        checks++; if (zero !== 1'b1 || Cout !== 1'b1) begin errors++; $display("FAIL mrst_pre_flags: zero %b Cout %b expected 1 1", zero, Cout); end
        rst = 1'b1;
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid: got %b expected 0", out_valid); end
        checks++; if ({S, Cout, ovf, zero} !== 19'h0) begin errors++; $display("FAIL mrst_outputs: S %h Cout %b ovf %b zero %b expected all 0", S, Cout, ovf, zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        X = 16'h0100; Y = 16'h0023; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick;
            checks++;
            if (out_valid !== (c == 4)) begin errors++; $display("FAIL mrst_post_valid c%0d: got %b expected %b", c, out_valid, (c == 4)); end
            if (c == 4) begin
                checks++;
                if (S !== 16'h0123) begin errors++; $display("FAIL mrst_post_S: got %h expected 0123", S); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_order();
        test_stall();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
